// File: rtl/chip8_fb_pkg.sv
// Shared types and geometry for the CHIP-8 framebuffer: engine states, command
// opcodes and the row/column-byte to byte-address mapping.
package chip8_fb_pkg;

  localparam int FB_COLS  = 64;
  localparam int FB_ROWS  = 32;
  localparam int FB_BYTES = FB_COLS * FB_ROWS / 8;
  localparam int ROW_W    = $clog2(FB_ROWS);
  localparam int COLB_W   = $clog2(FB_COLS / 8);
  localparam int FB_AW    = ROW_W + COLB_W;

  localparam logic OP_DRAW  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_LOAD,
    S_MOD_A,
    S_RD_B,
    S_MOD_B,
    S_DONE
  } fb_state_t;

  // Row-major layout: eight bytes per row, MSB is the leftmost pixel.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [ROW_W-1:0]  row,
                                               input logic [COLB_W-1:0] colbyte);
    return {row, colbyte};
  endfunction

endpackage

// File: rtl/chip8_fb_ram.sv
// 256x8 dual-port framebuffer RAM: port A read/write for the draw engine,
// port B read-only for the display. Both reads are registered, old-data on collision.
module chip8_fb_ram
  import chip8_fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [FB_AW-1:0] a_addr,
  input  logic             a_we,
  input  logic [7:0]       a_wdata,
  output logic [7:0]       a_rdata,
  input  logic [FB_AW-1:0] b_addr,
  output logic [7:0]       b_rdata
);

  logic [7:0] mem [FB_BYTES];

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM
  // and survives a reset; non-blocking writes give old-data read-during-write.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) b_rdata <= '0;
    else          b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/chip8_framebuffer.sv
// CHIP-8 64x32 framebuffer with display read port and a DRW/CLS engine that
// XORs sprites in with wrap-around and reports pixel collision.
module chip8_framebuffer
  import chip8_fb_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        disp_addr,
  output logic [7:0]        disp_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_n,
  input  logic [MEM_AW-1:0] cmd_i,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  fb_state_t         state, state_nxt;
  logic [5:0]        x6;
  logic [4:0]        y5;
  logic [3:0]        n;
  logic [MEM_AW-1:0] base;
  logic [7:0]        idx;
  logic [7:0]        sprite;
  logic              coll, coll_hold;

  logic              accept;
  logic [2:0]        shift;
  logic [4:0]        row;
  logic [2:0]        col_a, col_b;
  logic [7:0]        pat_a, pat_b, pat;
  logic              hit, row_last;
  logic              ram_we;
  logic [FB_AW-1:0]  ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic              unused;

  assign unused    = ^{cmd_x[7:6], cmd_y[7:5]};
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;

  assign shift    = x6[2:0];
  assign row      = y5 + idx[4:0];
  assign col_a    = x6[5:3];
  assign col_b    = col_a + 3'd1;
  assign pat_a    = sprite >> shift;
  assign pat_b    = sprite << (4'd8 - {1'b0, shift});
  assign pat      = (state == S_MOD_B) ? pat_b : pat_a;
  assign hit      = |(ram_rdata & pat);
  assign row_last = (idx[3:0] + 4'd1 == n);
  // The accumulator is only final in DONE; afterwards the held copy is shown.
  assign collision = (state == S_DONE) ? coll : coll_hold;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = fb_addr(row, col_a);
    ram_wdata = '0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      S_IDLE: if (accept) begin
        if (cmd_op == OP_CLEAR) state_nxt = S_CLR;
        else if (cmd_n == 4'd0) state_nxt = S_DONE;
        else                    state_nxt = S_FETCH;
      end
      S_CLR: begin
        ram_we   = 1'b1;
        ram_addr = idx;
        if (idx == 8'hFF) state_nxt = S_DONE;
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = base + MEM_AW'(idx[3:0]);
        state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_MOD_A;
      S_MOD_A: begin
        ram_we    = 1'b1;
        ram_wdata = ram_rdata ^ pat;
        if (shift != 3'd0) state_nxt = S_RD_B;
        else               state_nxt = row_last ? S_DONE : S_FETCH;
      end
      S_RD_B: begin
        ram_addr  = fb_addr(row, col_b);
        state_nxt = S_MOD_B;
      end
      S_MOD_B: begin
        ram_we    = 1'b1;
        ram_addr  = fb_addr(row, col_b);
        ram_wdata = ram_rdata ^ pat;
        state_nxt = row_last ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      x6        <= '0;
      y5        <= '0;
      n         <= '0;
      base      <= '0;
      idx       <= '0;
      sprite    <= '0;
      coll      <= 1'b0;
      coll_hold <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          x6        <= cmd_x[5:0];
          y5        <= cmd_y[4:0];
          n         <= cmd_n;
          base      <= cmd_i;
          idx       <= '0;
          coll      <= 1'b0;
          coll_hold <= 1'b0;
        end
        S_CLR:   idx <= idx + 8'd1;
        S_LOAD:  sprite <= mem_rdata;
        S_MOD_A: begin
          coll <= coll | hit;
          if (shift == 3'd0) idx <= idx + 8'd1;
        end
        S_MOD_B: begin
          coll <= coll | hit;
          idx  <= idx + 8'd1;
        end
        S_DONE:  coll_hold <= coll;
        default: ;
      endcase
    end
  end

  chip8_fb_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_addr  (ram_addr),
    .a_we    (ram_we),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_addr  (disp_addr),
    .b_rdata (disp_data)
  );

endmodule
